small_fallthrough_fifo: RTL and testbench

Small first-word-fall-through (FWFT) FIFO used as the input buffer of the output-port-lookup stage. The head word is always presented on `dout` while `empty` is low, and `rd_en` pops it. `nearly_full` provides one word of slack for AXI-Stream backpressure: upstream `tready` is driven from `!nearly_full`.

---
 rtl/small_fallthrough_fifo.sv | 84 ++++++++
 tb/tb_small_fallthrough_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/small_fallthrough_fifo.sv
// First-word-fall-through FIFO: head word is shown on dout while empty is low, rd_en pops it.
// Define SMALL_FIFO_CHECK_EN to compile in simulation-only overflow/underflow messages.
module small_fallthrough_fifo #(
    parameter int unsigned WIDTH               = 72,
    parameter int unsigned MAX_DEPTH_BITS      = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;

    localparam logic [MAX_DEPTH_BITS:0] C_DEPTH      = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] C_NEAR_FULL  = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);
    localparam logic [MAX_DEPTH_BITS:0] C_PROG_FULL  = (MAX_DEPTH_BITS + 1)'(PROG_FULL_THRESHOLD);
    localparam logic [MAX_DEPTH_BITS:0] C_CNT_ONE    = (MAX_DEPTH_BITS + 1)'(1);
    localparam logic [MAX_DEPTH_BITS-1:0] C_PTR_ONE  = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;

    logic w_wr_accept;
    logic w_rd_accept;

    // Acceptance is gated only by registered flags, so a pop never frees room for a same-cycle push.
    assign w_wr_accept = wr_en && !full;
    assign w_rd_accept = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout        = r_mem[r_rd_ptr];
    assign full        = (r_count == C_DEPTH);
    assign nearly_full = (r_count >= C_NEAR_FULL);
    assign prog_full   = (r_count >= C_PROG_FULL);
    assign empty       = (r_count == '0);

`ifdef SMALL_FIFO_CHECK_EN
    always @(posedge clk) begin
        if (!reset && wr_en && full) begin
            $error("%0t %m: write while full, word dropped", $time);
        end
        if (!reset && rd_en && empty) begin
            $error("%0t %m: read while empty, ignored", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_small_fallthrough_fifo.sv
// Directed bench for small_fallthrough_fifo with WIDTH=8, D=4, prog_full threshold 2.
// Every comparison is an immediate assertion with hand-computed expectations.
module tb_small_fallthrough_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       nearly_full;
    logic       prog_full;
    logic       empty;

    int vectors;
    int errors;

    small_fallthrough_fifo #(
        .WIDTH               (8),
        .MAX_DEPTH_BITS      (2),
        .PROG_FULL_THRESHOLD (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
        .prog_full   (prog_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic e_empty, input logic e_pf,
                         input logic e_nf, input logic e_full);
        chk1({tag, ".empty"}, empty, e_empty);
        chk1({tag, ".prog_full"}, prog_full, e_pf);
        chk1({tag, ".nearly_full"}, nearly_full, e_nf);
        chk1({tag, ".full"}, full, e_full);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b0;
        din     = 8'h00;
        wr_en   = 1'b0;
        rd_en   = 1'b0;

        // asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        flags("reset_async", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // single write then single read
        din = 8'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk1("single.empty", empty, 1'b0);
        chk8("single.dout", dout, 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk1("single.empty_after_read", empty, 1'b1);

        // fill with 01..04
        wr_en = 1'b1;
        din = 8'h01; tick();
        flags("fill1", 1'b0, 1'b0, 1'b0, 1'b0);
        din = 8'h02; tick();
        flags("fill2", 1'b0, 1'b1, 1'b0, 1'b0);
        din = 8'h03; tick();
        flags("fill3", 1'b0, 1'b1, 1'b1, 1'b0);
        din = 8'h04; tick();
        flags("fill4", 1'b0, 1'b1, 1'b1, 1'b1);
        din = 8'h05; tick();
        wr_en = 1'b0;
        chk1("overflow.full", full, 1'b1);
        chk8("overflow.head", dout, 8'h01);

        // drain: 01..04, 05 must not appear
        rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk8("drain.dout", dout, 8'(i));
            chk1("drain.not_empty", empty, 1'b0);
            tick();
        end
        rd_en = 1'b0;
        flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);

        // streaming at occupancy 2 across pointer wrap
        wr_en = 1'b1;
        din = 8'h10; tick();
        din = 8'h11; tick();
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 8'(8'h12 + i);
            chk8("stream.dout", dout, 8'(8'h10 + i));
            tick();
            flags("stream", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        wr_en = 1'b0;
        chk8("stream.tail0", dout, 8'h1A);
        tick();
        chk8("stream.tail1", dout, 8'h1B);
        tick();
        rd_en = 1'b0;
        chk1("stream.empty", empty, 1'b1);

        // read while empty combined with a write
        din = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk1("rd_empty_wr.empty", empty, 1'b0);
        chk8("rd_empty_wr.dout", dout, 8'h3C);
        tick();
        chk8("rd_empty_wr.dout_hold", dout, 8'h3C);

        // fill to full, then write-while-full with a same-cycle read
        wr_en = 1'b1;
        din = 8'h40; tick();
        din = 8'h41; tick();
        din = 8'h42; tick();
        chk1("refill.full", full, 1'b1);
        din = 8'h99; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        flags("full_rw", 1'b0, 1'b1, 1'b1, 1'b0);
        chk8("full_rw.dout", dout, 8'h40);

        // reset with 3 words stored, mid-cycle
        #2 reset = 1'b1;
        #1;
        flags("reset_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        din = 8'h77; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk1("post_reset.empty", empty, 1'b0);
        chk8("post_reset.dout", dout, 8'h77);
        chk1("post_reset.prog_full", prog_full, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk1("post_reset.empty_after_read", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
